// File: rtl/rt_subaddr_ctrl.sv
// Remote-terminal subaddress controller: decodes command words, buffers receive data per
// subaddress, returns status after the response gap and streams transmit data to the encoder.
module rt_subaddr_ctrl #(
    parameter logic [4:0] RT_ADDR = 5'd1,
    parameter int         NUM_SA  = 4,
    parameter int         GAP_CYC = 8,
    parameter int         RX_TMO  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic        rx_valid,
    input  logic [15:0] rx_data,
    input  logic        p_error,
    output logic [15:0] tx_data,
    output logic        tx_cd,
    output logic        tx_ready,
    input  logic        tx_busy,
    input  logic        host_we,
    input  logic [4:0]  host_sa,
    input  logic [4:0]  host_addr,
    input  logic [15:0] host_wdata,
    output logic [15:0] host_rdata,
    output logic        busy,
    output logic [7:0]  err_cnt
);
    localparam int          SAW      = (NUM_SA > 1) ? $clog2(NUM_SA) : 1;
    localparam logic [4:0]  NSA      = 5'(NUM_SA);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);
    localparam logic [15:0] TMO_LAST = 16'(RX_TMO - 1);

    typedef enum logic [3:0] {
        IDLE, DECODE, RX_DATA, GAP, SEND_SW, TX_RD, TX_SEND, TX_WAIT, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cmd_q;
    logic [4:0]  idx;
    logic [15:0] tmr;
    logic        me;
    logic        rx_we, me_set, idx_inc, tmo;

    logic [15:0] mem [NUM_SA][32];

    logic [4:0] cmd_addr, cmd_sa, cmd_wc, last_idx, sa_m1, host_m1;
    logic       cmd_tr, bcast, for_us, mode, legal, host_ok;
    logic [SAW-1:0] sa_idx, host_idx;

    assign cmd_addr = cmd_q[15:11];
    assign cmd_tr   = cmd_q[10];
    assign cmd_sa   = cmd_q[9:5];
    assign cmd_wc   = cmd_q[4:0];
    // Count 0 means 32: last index 31 falls out of 5-bit wrap.
    assign last_idx = cmd_wc - 5'd1;
    assign bcast    = (cmd_addr == 5'd31);
    assign for_us   = (cmd_addr == RT_ADDR) || bcast;
    assign mode     = (cmd_sa == 5'd0) || (cmd_sa == 5'd31);
    // SA 0 wraps to 31 after the decrement, so it never passes the range check.
    assign sa_m1    = cmd_sa - 5'd1;
    assign legal    = (sa_m1 < NSA) && (cmd_sa != 5'd31);
    assign sa_idx   = sa_m1[SAW-1:0];
    assign host_m1  = host_sa - 5'd1;
    assign host_ok  = (host_m1 < NSA) && (host_sa != 5'd31);
    assign host_idx = host_m1[SAW-1:0];
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        tx_ready  = 1'b0;
        rx_we     = 1'b0;
        me_set    = 1'b0;
        idx_inc   = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: if (cmd_valid) state_nxt = DECODE;
            DECODE: begin
                if (!for_us || (bcast && cmd_tr)) begin
                    state_nxt = IDLE;
                end else begin
                    me_set    = !mode && !legal;
                    state_nxt = (cmd_tr || mode) ? GAP : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cmd_valid) begin
                    state_nxt = DECODE;
                end else if (rx_valid) begin
                    rx_we  = legal;
                    me_set = p_error;
                    if (idx == last_idx) state_nxt = GAP;
                    else                 idx_inc   = 1'b1;
                end else if (tmr == TMO_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            GAP: if (tmr == GAP_LAST) state_nxt = bcast ? DONE : SEND_SW;
            SEND_SW: begin
                if (!tx_busy) begin
                    tx_ready  = 1'b1;
                    state_nxt = (cmd_tr && legal) ? TX_RD : DONE;
                end
            end
            TX_RD: state_nxt = TX_SEND;
            TX_SEND: begin
                if (!tx_busy) begin
                    tx_ready  = 1'b1;
                    state_nxt = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (!tx_busy) begin
                    if (idx == last_idx) begin
                        state_nxt = DONE;
                    end else begin
                        idx_inc   = 1'b1;
                        state_nxt = TX_RD;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cmd_q   <= '0;
            idx     <= '0;
            tmr     <= '0;
            me      <= 1'b0;
            err_cnt <= '0;
            tx_data <= '0;
            tx_cd   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cmd_valid && (state == IDLE || state == RX_DATA)) cmd_q <= rx_data;
            // One timer serves both the response gap and the inter-word timeout.
            if (state_nxt != state || (rx_valid && state == RX_DATA)) tmr <= '0;
            else                                                       tmr <= tmr + 16'd1;
            if (state_nxt == DECODE || state_nxt == IDLE) begin
                idx <= '0;
                me  <= 1'b0;
            end else begin
                if (idx_inc) idx <= idx + 5'd1;
                if (me_set)  me  <= 1'b1;
            end
            if (((state == DONE && me) || tmo) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (state == GAP && state_nxt == SEND_SW) begin
                tx_data <= {RT_ADDR, me, 10'd0};
                tx_cd   <= 1'b0;
            end else if (state == TX_RD) begin
                tx_data <= mem[sa_idx][idx];
                tx_cd   <= 1'b1;
            end
        end
    end

    // Receive write is issued after the host write so it wins on a same-location collision.
    always_ff @(posedge clk) begin
        if (host_we && host_ok) mem[host_idx][host_addr] <= host_wdata;
        if (rx_we)              mem[sa_idx][idx]         <= rx_data;
        host_rdata <= host_ok ? mem[host_idx][host_addr] : '0;
    end
endmodule

// File: tb/tb_rt_subaddr_ctrl.sv
// Scoreboard bench for rt_subaddr_ctrl: a message-level model pushes expected encoder words,
// a negedge monitor pops and compares them against every tx_ready pulse.
module tb_rt_subaddr_ctrl;
    localparam logic [4:0] RT  = 5'd1;
    localparam int         NSA = 4;
    localparam int         GAP = 8;
    localparam int         TMO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, rx_valid, p_error, tx_cd, tx_ready, tx_busy, host_we, busy;
    logic [15:0] rx_data, tx_data, host_wdata, host_rdata;
    logic [4:0]  host_sa, host_addr;
    logic [7:0]  err_cnt;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [16:0] exp_q[$];
    logic [15:0] mm [0:NSA][0:31];
    int          exp_err = 0;
    bit          gap_chk = 0;
    int          gap_ref = 0;

    rt_subaddr_ctrl #(.RT_ADDR(RT), .NUM_SA(NSA), .GAP_CYC(GAP), .RX_TMO(TMO)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .rx_valid(rx_valid),
        .rx_data(rx_data), .p_error(p_error), .tx_data(tx_data), .tx_cd(tx_cd),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .host_we(host_we), .host_sa(host_sa),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Encoder: stays busy for a random 2..5 cycles after each accepted word.
    initial begin
        int  bcnt;
        bit  rs;
        bcnt = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            rs = tx_ready;
            @(posedge clk);
            #1;
            if (reset)          bcnt = 0;
            else if (rs)        bcnt = $urandom_range(2, 5);
            else if (bcnt > 0)  bcnt--;
            tx_busy = (bcnt != 0);
        end
    end

    always @(negedge clk) begin
        if (!reset && tx_ready) begin
            logic [16:0] e;
            chk("ready_while_busy", {31'd0, tx_busy}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got cd=%0b data=%0h expected no word", tx_cd, tx_data);
            end else begin
                e = exp_q.pop_front();
                chk("tx_word", {15'd0, tx_cd, tx_data}, {15'd0, e});
                if (!e[16] && gap_chk) begin
                    chk("status_gap", 32'(cyc - gap_ref), 32'(GAP + 1));
                    gap_chk = 0;
                end
            end
        end
    end

    task automatic send_cmd(input logic [15:0] w);
        cmd_valid = 1'b1;
        rx_data   = w;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic host_write(input logic [4:0] sa, input logic [4:0] ad, input logic [15:0] d);
        host_we = 1'b1; host_sa = sa; host_addr = ad; host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
        mm[sa][ad] = d;
    endtask

    task automatic host_check(input logic [4:0] sa, input logic [4:0] ad);
        host_sa = sa; host_addr = ad;
        @(negedge clk);
        chk("host_rdata", {16'd0, host_rdata}, {16'd0, mm[sa][ad]});
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s: busy=%0b after %0d cycles, expected 0", nm, busy, k);
        end
    endtask

    // Whole-message model: who responds, which status, which data, whether it counts as an error.
    task automatic run_msg(input logic [4:0] a, input bit tr, input logic [4:0] sa,
                           input logic [4:0] wc, input int nsend, input int perr_at,
                           input bit collide);
        logic [15:0] w [32];
        int n;
        bit resp, mode, legal, me, rx, tmo_exp;
        n       = (wc == 5'd0) ? 32 : int'(wc);
        resp    = (a == RT) || (a == 5'd31 && !tr);
        mode    = (sa == 5'd0) || (sa == 5'd31);
        legal   = !mode && (int'(sa) <= NSA);
        me      = resp && !mode && !legal;
        rx      = resp && !tr && !mode;
        tmo_exp = rx && (nsend < n);
        for (int i = 0; i < 32; i++) w[i] = 16'($urandom);
        if (rx) begin
            for (int i = 0; i < nsend; i++) begin
                if (legal) mm[sa][i] = w[i];
                if (i == perr_at) me = 1'b1;
            end
        end
        if (resp && !tmo_exp && a != 5'd31) begin
            exp_q.push_back({1'b0, RT, me, 10'd0});
            if (tr && legal) for (int i = 0; i < n; i++) exp_q.push_back({1'b1, mm[sa][i]});
        end
        if ((tmo_exp || (resp && me)) && exp_err < 255) exp_err++;

        send_cmd({a, tr, sa, wc});
        if (rx) begin
            for (int i = 0; i < nsend; i++) begin
                repeat ((i == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3)) @(negedge clk);
                rx_valid = 1'b1; rx_data = w[i]; p_error = (i == perr_at);
                if (collide && legal) begin
                    host_we = 1'b1; host_sa = sa; host_addr = 5'(i); host_wdata = ~w[i];
                end
                if (i == n - 1 && a != 5'd31) begin
                    gap_ref = cyc;
                    gap_chk = 1;
                end
                @(negedge clk);
                rx_valid = 1'b0; p_error = 1'b0; host_we = 1'b0;
            end
        end
        wait_idle("msg_idle");
        chk("err_cnt", {24'd0, err_cnt}, 32'(exp_err));
        chk("tx_words_missing", 32'(exp_q.size()), 32'd0);
        if (rx && legal) for (int i = 0; i < nsend; i++) host_check(sa, 5'(i));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        reset = 1'b1;
        cmd_valid = 0; rx_valid = 0; rx_data = 0; p_error = 0;
        host_we = 0; host_sa = 0; host_addr = 0; host_wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        chk("rst_tx_cd",    {31'd0, tx_cd},    32'd0);
        chk("rst_tx_data",  {16'd0, tx_data},  32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_err_cnt",  {24'd0, err_cnt},  32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int s = 1; s <= NSA; s++)
            for (int i = 0; i < 32; i++) host_write(5'(s), 5'(i), 16'($urandom));
        repeat (8) host_check(5'($urandom_range(1, NSA)), 5'($urandom_range(0, 31)));

        run_msg(RT, 1'b0, 5'd2, 5'd3, 3, -1, 1'b0);        // receive 3 words, clean status
        run_msg(RT, 1'b1, 5'd1, 5'd0, 0, -1, 1'b0);        // transmit 32 words
        run_msg(RT, 1'b0, 5'd3, 5'd2, 2, 1, 1'b0);         // parity error on 2nd word
        send_cmd({5'd5, 1'b0, 5'd2, 5'd3});
        chk("other_rt_busy_decode", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("other_rt_busy_drop", {31'd0, busy}, 32'd0);
        run_msg(5'd31, 1'b0, 5'd2, 5'd3, 3, -1, 1'b0);     // broadcast receive
        run_msg(RT, 1'b0, 5'd4, 5'd4, 2, -1, 1'b0);        // receive timeout
        run_msg(RT, 1'b0, 5'd3, 5'd0, 32, -1, 1'b0);       // full 32-word receive
        run_msg(RT, 1'b1, 5'd3, 5'd0, 0, -1, 1'b0);
        run_msg(RT, 1'b0, 5'd1, 5'd4, 4, -1, 1'b1);        // host write collides with receive
        run_msg(RT, 1'b0, 5'd0, 5'd17, 0, -1, 1'b0);       // mode codes
        run_msg(RT, 1'b1, 5'd31, 5'd2, 0, -1, 1'b0);
        run_msg(RT, 1'b0, 5'd9, 5'd3, 3, -1, 1'b0);        // illegal subaddresses
        run_msg(RT, 1'b1, 5'd6, 5'd2, 0, -1, 1'b0);
        run_msg(5'd31, 1'b1, 5'd1, 5'd2, 0, -1, 1'b0);     // broadcast transmit ignored

        for (int m = 0; m < 40; m++) begin
            logic [4:0] a, sa, wc;
            int r, n, pe, ns;
            r  = $urandom_range(0, 9);
            a  = (r < 6) ? RT : (r < 8) ? 5'd31 : 5'($urandom_range(0, 30));
            r  = $urandom_range(0, 9);
            sa = (r < 7) ? 5'($urandom_range(1, NSA)) : (r == 7) ? ($urandom_range(0, 1) ? 5'd31 : 5'd0)
                         : 5'($urandom_range(NSA + 1, 30));
            wc = 5'($urandom_range(0, 31));
            n  = (wc == 5'd0) ? 32 : int'(wc);
            pe = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
            ns = ($urandom_range(0, 9) == 0 && n > 1) ? $urandom_range(1, n - 1) : n;
            run_msg(a, 1'($urandom_range(0, 1)), sa, wc, ns, pe, 1'($urandom_range(0, 3) == 0));
        end

        repeat (260) run_msg(RT, 1'b1, 5'd7, 5'd1, 0, -1, 1'b0);   // drive err_cnt to saturation

        for (int i = 0; i < 8; i++) exp_q.push_back(17'd0);
        exp_q.delete();
        exp_q.push_back({1'b0, RT, 1'b0, 10'd0});
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, mm[4][i]});
        send_cmd({RT, 1'b1, 5'd4, 5'd8});
        k = 0;
        while (exp_q.size() > 6 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("reached_tx_data_phase", {31'd0, exp_q.size() <= 6}, 32'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("midrst_tx_ready", {31'd0, tx_ready}, 32'd0);
        chk("midrst_tx_cd",    {31'd0, tx_cd},    32'd0);
        chk("midrst_tx_data",  {16'd0, tx_data},  32'd0);
        chk("midrst_busy",     {31'd0, busy},     32'd0);
        chk("midrst_err_cnt",  {24'd0, err_cnt},  32'd0);
        exp_q.delete();
        exp_err = 0;
        gap_chk = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        chk("post_rst_busy",    {31'd0, busy},    32'd0);
        chk("post_rst_err_cnt", {24'd0, err_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
